// File: rtl/img_pkg.sv
// Shared pixel/gradient types and helpers for the image pipeline.
package img_pkg;

  localparam int unsigned DW      = 8;
  localparam int unsigned GRAD_W  = DW + 3;
  localparam int unsigned PIX_MAX = (1 << DW) - 1;

  typedef logic [DW-1:0]            pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;

  // Per-window attributes that travel alongside the arithmetic.
  typedef struct packed {
    logic   valid;
    logic   interior;
    logic   eof;
    pixel_t threshold;
  } side_t;

  // Weighted 1-2-1 sum of three pixels, widened to gradient width.
  function automatic mag_t wsum(input pixel_t a, input pixel_t b, input pixel_t c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  // Absolute value of a gradient; |g| <= 1020 so no overflow on negation.
  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/pixel_pos_tracker.sv
// Tracks the frame position of the newest window pixel and flags border/last beats.
module pixel_pos_tracker #(
  parameter int unsigned IMG_W = 100,
  parameter int unsigned IMG_H = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic sof,
  output logic interior_c,
  output logic last_pixel_c
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             resync;

  // Position of the current beat: sof forces (0,0) on the same beat.
  always_comb begin
    resync       = in_valid & sof;
    cur_col      = resync ? '0 : col;
    cur_row      = resync ? '0 : row;
    interior_c   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    last_pixel_c = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
  end

  // Advance on every accepted window, wrapping at line and frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_pixel_c) begin
        col <= '0;
        row <= '0;
      end else if (cur_col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
      end
    end
  end

endmodule

// File: rtl/sobel_edge_stage.sv
// Three-stage Sobel edge detector; out_valid follows in_valid by three cycles.
module sobel_edge_stage
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = 100,
  parameter int unsigned IMG_H = 100
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  logic   sof,
  input  pixel_t i11,
  input  pixel_t i12,
  input  pixel_t i13,
  input  pixel_t i21,
  input  pixel_t i22,
  input  pixel_t i23,
  input  pixel_t i31,
  input  pixel_t i32,
  input  pixel_t i33,
  input  pixel_t threshold,
  output logic   out_valid,
  output pixel_t edge_mag,
  output logic   edge_bit,
  output logic   eof
);

  logic   interior_c;
  logic   last_pixel_c;
  grad_t  gx_c;
  grad_t  gy_c;
  mag_t   sum_c;
  pixel_t sat_c;

  side_t  s1_side;
  grad_t  s1_gx;
  grad_t  s1_gy;
  side_t  s2_side;
  mag_t   s2_ax;
  mag_t   s2_ay;

  pixel_pos_tracker #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .sof          (sof),
    .interior_c   (interior_c),
    .last_pixel_c (last_pixel_c)
  );

  // Gradients and saturated magnitude; the centre pixel i22 has zero weight.
  always_comb begin
    gx_c  = grad_t'(wsum(i13, i23, i33) - wsum(i11, i21, i31));
    gy_c  = grad_t'(wsum(i31, i32, i33) - wsum(i11, i12, i13));
    sum_c = s2_ax + s2_ay;
    sat_c = (sum_c > mag_t'(PIX_MAX)) ? pixel_t'(PIX_MAX) : sum_c[DW-1:0];
  end

  // S1: capture gradients together with threshold, border and eof flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_side <= '0;
      s1_gx   <= '0;
      s1_gy   <= '0;
    end else begin
      s1_side.valid <= in_valid;
      if (in_valid) begin
        s1_side.interior  <= interior_c;
        s1_side.eof       <= last_pixel_c;
        s1_side.threshold <= threshold;
        s1_gx             <= gx_c;
        s1_gy             <= gy_c;
      end
    end
  end

  // S2: absolute gradients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_side <= '0;
      s2_ax   <= '0;
      s2_ay   <= '0;
    end else begin
      s2_side.valid <= s1_side.valid;
      if (s1_side.valid) begin
        s2_side.interior  <= s1_side.interior;
        s2_side.eof       <= s1_side.eof;
        s2_side.threshold <= s1_side.threshold;
        s2_ax             <= abs_grad(s1_gx);
        s2_ay             <= abs_grad(s1_gy);
      end
    end
  end

  // S3: mask border windows, threshold, drive outputs; data holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      edge_mag  <= '0;
      edge_bit  <= 1'b0;
      eof       <= 1'b0;
    end else begin
      out_valid <= s2_side.valid;
      eof       <= s2_side.valid & s2_side.eof;
      if (s2_side.valid) begin
        edge_mag <= s2_side.interior ? sat_c : '0;
        edge_bit <= s2_side.interior && (sat_c >= s2_side.threshold);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Directed testbench for sobel_edge_stage.
module tb_sobel_edge_stage;
  import img_pkg::*;

  localparam int IMG_W = 100;
  localparam int IMG_H = 100;
  localparam int BASE  = 2 * IMG_W + 2;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  logic   sof;
  pixel_t i11, i12, i13, i21, i22, i23, i31, i32, i33;
  pixel_t threshold;
  logic   out_valid;
  pixel_t edge_mag;
  logic   edge_bit;
  logic   eof;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  int     acc_q[$];
  int     res_cyc[$];
  pixel_t res_mag[$];
  logic   res_bit[$];
  logic   res_eof[$];

  sobel_edge_stage #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof),
    .i11(i11), .i12(i12), .i13(i13), .i21(i21), .i22(i22), .i23(i23),
    .i31(i31), .i32(i32), .i33(i33), .threshold(threshold),
    .out_valid(out_valid), .edge_mag(edge_mag), .edge_bit(edge_bit), .eof(eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record input beats and results mid-cycle.
  always @(negedge clk) begin
    if (in_valid) acc_q.push_back(cyc);
    if (out_valid) begin
      res_cyc.push_back(cyc);
      res_mag.push_back(edge_mag);
      res_bit.push_back(edge_bit);
      res_eof.push_back(eof);
    end
  end

  function automatic logic [71:0] w33(input pixel_t v);
    return {64'd0, v};
  endfunction

  task automatic drive(input logic v, input logic s, input logic [71:0] w, input pixel_t thr);
    @(posedge clk);
    #1;
    in_valid  = v;
    sof       = s;
    {i11, i12, i13, i21, i22, i23, i31, i32, i33} = w;
    threshold = thr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 72'd0, 8'd0);
  endtask

  task automatic clear_mon;
    acc_q.delete();
    res_cyc.delete();
    res_mag.delete();
    res_bit.delete();
    res_eof.delete();
  endtask

  // sof beat at (0,0) then zero beats until the next beat sits at (2,2).
  task automatic goto_interior(input pixel_t thr);
    drive(1'b1, 1'b1, 72'd0, thr);
    repeat (BASE - 1) drive(1'b1, 1'b0, 72'd0, thr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; threshold = 8'd0;
    {i11, i12, i13, i21, i22, i23, i31, i32, i33} = 72'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (edge_mag !== 8'd0) begin errors++; $display("FAIL reset_edge_mag: got %0d expected 0", edge_mag); end
    checks++; if (edge_bit !== 1'b0) begin errors++; $display("FAIL reset_edge_bit: got %b expected 0", edge_bit); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b expected 0", eof); end
    checks++; if (dut.u_pos.col !== 7'd0 || dut.u_pos.row !== 7'd0) begin
      errors++; $display("FAIL reset_pos: got col %0d row %0d expected 0 0", dut.u_pos.col, dut.u_pos.row);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    clear_mon();
  endtask

  task automatic test_flat;
    int bad;
    clear_mon();
    goto_interior(8'd0);
    drive(1'b1, 1'b0, {9{8'd128}}, 8'd10);
    drive(1'b1, 1'b0, {9{8'd128}}, 8'd0);
    idle(5);
    checks++; if (res_mag.size() != BASE + 2) begin errors++; $display("FAIL flat_count: got %0d expected %0d", res_mag.size(), BASE + 2); end
    bad = 0;
    for (int k = 0; k < BASE && k < res_mag.size(); k++)
      if (res_mag[k] !== 8'd0 || res_bit[k] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL border_mask: got %0d non-zero border results expected 0", bad); end
    checks++; if (res_mag[BASE] !== 8'd0 || res_bit[BASE] !== 1'b0) begin
      errors++; $display("FAIL flat_thr10: got mag %0d bit %b expected 0 0", res_mag[BASE], res_bit[BASE]);
    end
    checks++; if (res_mag[BASE+1] !== 8'd0 || res_bit[BASE+1] !== 1'b1) begin
      errors++; $display("FAIL flat_thr0: got mag %0d bit %b expected 0 1", res_mag[BASE+1], res_bit[BASE+1]);
    end
    bad = 0;
    for (int k = 0; k < res_cyc.size(); k++)
      if (k >= acc_q.size() || res_cyc[k] - acc_q[k] != 3) bad++;
    checks++; if (bad != 0 || acc_q.size() != res_cyc.size()) begin
      errors++; $display("FAIL flat_latency: got %0d off-latency results expected 0", bad);
    end
  endtask

  task automatic test_gradients;
    logic [71:0] wv [6];
    pixel_t      tv [6];
    pixel_t      em [6];
    logic        eb [6];
    wv = '{ {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255},
            {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255},
            {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0},
            {8'd20, 64'd0},
            {8'd0, 8'd0, 8'd0, 8'd5, 40'd0},
            {8'd0, 8'd0, 8'd30, 48'd0} };
    tv = '{8'd200, 8'd200, 8'd255, 8'd0, 8'd11, 8'd0};
    em = '{8'd255, 8'd255, 8'd255, 8'd40, 8'd10, 8'd60};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    clear_mon();
    goto_interior(8'd0);
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, wv[k], tv[k]);
    idle(5);
    checks++; if (res_mag.size() != BASE + 6) begin errors++; $display("FAIL grad_count: got %0d expected %0d", res_mag.size(), BASE + 6); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (res_mag[BASE+k] !== em[k]) begin errors++; $display("FAIL grad_mag[%0d]: got %0d expected %0d", k, res_mag[BASE+k], em[k]); end
      checks++; if (res_bit[BASE+k] !== eb[k]) begin errors++; $display("FAIL grad_bit[%0d]: got %b expected %b", k, res_bit[BASE+k], eb[k]); end
    end
  endtask

  task automatic test_threshold;
    logic [71:0] wt;
    pixel_t em [5];
    logic   eb [5];
    wt = {16'd0, 8'd10, 16'd0, 8'd10, 16'd0, 8'd10};
    em = '{8'd40, 8'd40, 8'd254, 8'd255, 8'd100};
    eb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    clear_mon();
    goto_interior(8'd0);
    drive(1'b1, 1'b0, wt, 8'd40);
    drive(1'b1, 1'b0, wt, 8'd41);
    drive(1'b1, 1'b0, w33(8'd127), 8'd0);
    drive(1'b1, 1'b0, w33(8'd128), 8'd255);
    drive(1'b1, 1'b0, w33(8'd50), 8'd101);
    idle(5);
    checks++; if (res_mag.size() != BASE + 5) begin errors++; $display("FAIL thr_count: got %0d expected %0d", res_mag.size(), BASE + 5); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (res_mag[BASE+k] !== em[k]) begin errors++; $display("FAIL thr_mag[%0d]: got %0d expected %0d", k, res_mag[BASE+k], em[k]); end
      checks++; if (res_bit[BASE+k] !== eb[k]) begin errors++; $display("FAIL thr_bit[%0d]: got %b expected %b", k, res_bit[BASE+k], eb[k]); end
    end
  endtask

  task automatic test_gaps;
    int bad;
    clear_mon();
    goto_interior(8'd0);
    drive(1'b1, 1'b0, w33(8'd10), 8'd0);
    drive(1'b0, 1'b0, 72'd0, 8'd0);
    drive(1'b1, 1'b0, w33(8'd20), 8'd0);
    drive(1'b1, 1'b0, w33(8'd30), 8'd0);
    drive(1'b0, 1'b0, 72'd0, 8'd0);
    idle(5);
    checks++; if (res_mag.size() != BASE + 3) begin errors++; $display("FAIL gap_count: got %0d expected %0d", res_mag.size(), BASE + 3); end
    checks++; if (res_mag[BASE] !== 8'd20 || res_mag[BASE+1] !== 8'd40 || res_mag[BASE+2] !== 8'd60) begin
      errors++; $display("FAIL gap_values: got %0d %0d %0d expected 20 40 60", res_mag[BASE], res_mag[BASE+1], res_mag[BASE+2]);
    end
    checks++; if (res_cyc[BASE+1] - res_cyc[BASE] != 2 || res_cyc[BASE+2] - res_cyc[BASE+1] != 1) begin
      errors++; $display("FAIL gap_spacing: got %0d %0d expected 2 1", res_cyc[BASE+1] - res_cyc[BASE], res_cyc[BASE+2] - res_cyc[BASE+1]);
    end
    bad = 0;
    for (int k = 0; k < res_cyc.size(); k++)
      if (k >= acc_q.size() || res_cyc[k] - acc_q[k] != 3) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_latency: got %0d off-latency results expected 0", bad); end
    checks++; if (out_valid !== 1'b0 || edge_mag !== 8'd60) begin
      errors++; $display("FAIL hold: got valid %b mag %0d expected 0 60", out_valid, edge_mag);
    end
  endtask

  task automatic test_sof_resync;
    clear_mon();
    goto_interior(8'd0);
    drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    drive(1'b1, 1'b1, w33(8'd50), 8'd0);
    drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    idle(5);
    checks++; if (res_mag.size() != BASE + 4) begin errors++; $display("FAIL sof_count: got %0d expected %0d", res_mag.size(), BASE + 4); end
    checks++; if (res_mag[BASE] !== 8'd100 || res_mag[BASE+1] !== 8'd100) begin
      errors++; $display("FAIL sof_inflight: got %0d %0d expected 100 100", res_mag[BASE], res_mag[BASE+1]);
    end
    checks++; if (res_mag[BASE+2] !== 8'd0 || res_bit[BASE+2] !== 1'b0 || res_mag[BASE+3] !== 8'd0) begin
      errors++; $display("FAIL sof_resync: got %0d %b %0d expected 0 0 0", res_mag[BASE+2], res_bit[BASE+2], res_mag[BASE+3]);
    end
  endtask

  task automatic test_full_frame;
    int bad, eofs, eof_at, bad_lat, total;
    total = IMG_W * IMG_H + BASE + 1;
    clear_mon();
    drive(1'b1, 1'b1, w33(8'd50), 8'd0);
    repeat (total - 1) drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    idle(5);
    checks++; if (res_mag.size() != total) begin errors++; $display("FAIL frame_count: got %0d expected %0d", res_mag.size(), total); end
    bad = 0; eofs = 0; eof_at = -1; bad_lat = 0;
    for (int k = 0; k < res_mag.size(); k++) begin
      int p, r, c;
      logic inner;
      p = k % (IMG_W * IMG_H);
      r = p / IMG_W;
      c = p % IMG_W;
      inner = (r >= 2) && (c >= 2);
      if (res_mag[k] !== (inner ? 8'd100 : 8'd0) || res_bit[k] !== inner) bad++;
      if (res_eof[k] === 1'b1) begin eofs++; eof_at = k; end
      if (k >= acc_q.size() || res_cyc[k] - acc_q[k] != 3) bad_lat++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame_values: got %0d wrong results expected 0", bad); end
    checks++; if (eofs != 1 || eof_at != IMG_W * IMG_H - 1) begin
      errors++; $display("FAIL frame_eof: got %0d pulses at index %0d expected 1 at %0d", eofs, eof_at, IMG_W * IMG_H - 1);
    end
    checks++; if (bad_lat != 0) begin errors++; $display("FAIL frame_latency: got %0d off-latency results expected 0", bad_lat); end
  endtask

  task automatic test_reset_mid;
    clear_mon();
    goto_interior(8'd0);
    repeat (4) drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || edge_mag !== 8'd100 || edge_bit !== 1'b1) begin
      errors++; $display("FAIL prereset: got valid %b mag %0d bit %b expected 1 100 1", out_valid, edge_mag, edge_bit);
    end
    rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || edge_mag !== 8'd0 || edge_bit !== 1'b0 || eof !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got valid %b mag %0d bit %b eof %b expected 0 0 0 0", out_valid, edge_mag, edge_bit, eof);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    checks++; if (res_mag.size() != BASE + 1) begin errors++; $display("FAIL midreset_stale: got %0d results expected %0d", res_mag.size(), BASE + 1); end
    drive(1'b1, 1'b0, w33(8'd50), 8'd0);
    idle(5);
    checks++; if (res_mag.size() != BASE + 2 || res_mag[BASE+1] !== 8'd0 || res_bit[BASE+1] !== 1'b0) begin
      errors++; $display("FAIL postreset_first: got count %0d mag %0d expected %0d 0", res_mag.size(), res_mag[BASE+1], BASE + 2);
    end
    checks++; if (dut.u_pos.col !== 7'd1 || dut.u_pos.row !== 7'd0) begin
      errors++; $display("FAIL postreset_pos: got col %0d row %0d expected 1 0", dut.u_pos.col, dut.u_pos.row);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_gradients();
    test_threshold();
    test_gaps();
    test_sof_resync();
    test_full_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stage.md
# sobel_edge_stage

Pipelined Sobel edge detector that consumes the 3x3 pixel window produced by the line-buffer window generator (`i11`..`i33`, row-major, `i33` newest). Per accepted window it computes the horizontal and vertical gradients, forms a saturated magnitude and a thresholded edge bit, and masks border windows using an internal row/column tracker. Output feeds the frame writer / display stage.

## Interface
- `DW`, 8: pixel width.
- `IMG_W`, 100: pixels per line; equals line-buffer depth.
- `IMG_H`, 100: lines per frame.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  window valid this cycle; no backpressure.
- `sof`  in  1  start of frame, qualified by `in_valid`; marks pixel (0,0).
- `i11`..`i33`  in  DW each  3x3 window, row 1 = oldest line, column 3 = newest pixel.
- `threshold`  in  DW  edge threshold, sampled with the window.
- `out_valid`  out  1  result valid.
- `edge_mag`  out  DW  saturated gradient magnitude.
- `edge_bit`  out  1  `edge_mag >= threshold`.
- `eof`  out  1  pulse with the result for the last pixel of the frame.

## Operation
- Gx = (i13 + 2·i23 + i33) − (i11 + 2·i21 + i31); Gy = (i31 + 2·i32 + i33) − (i11 + 2·i12 + i13).
- Gx, Gy signed, GRAD_W = DW+3 = 11 bits (range ±1020); no overflow possible.
- Magnitude = |Gx| + |Gy|, GRAD_W unsigned (max 2040); saturate to 2^DW−1 = 255.
- edge_bit = 1 when saturated magnitude >= threshold (threshold 0 → every valid result is an edge).
- Position tracker: `col` 0..IMG_W−1, `row` 0..IMG_H−1, advance only on `in_valid`.
  - `in_valid && sof`: this beat is (0,0); next is (0,1).
  - col = IMG_W−1 → col 0, row+1; (IMG_H−1, IMG_W−1) → (0,0), and this beat's result carries `eof`.
- Border mask: window is interior when row >= 2 and col >= 2 (newest pixel coordinate). Non-interior beats still produce `out_valid`, with `edge_mag`=0, `edge_bit`=0.
- `threshold`, mask flag and eof flag travel with the data through the pipeline; a mid-frame threshold change affects only windows accepted afterwards.

## Timing
- 3-stage pipeline, latency 3: window accepted at edge N → `out_valid` high after edge N+3.
  - S1: register Gx, Gy, threshold, mask, eof.
  - S2: register |Gx|, |Gy|.
  - S3: register saturated sum, compare, drive outputs.
- Throughput one window per clock; `in_valid` gaps propagate as `out_valid` gaps with the same spacing.
- Reset values: `out_valid`=0, `edge_mag`=0, `edge_bit`=0, `eof`=0, `col`=0, `row`=0, all pipeline valids 0.
- Reset mid-frame: pipeline flushed, no output for in-flight windows; first beat after release is position (0,0) unless `sof` says otherwise.
- `sof` mid-frame: counters resync immediately; in-flight results complete unchanged.
- Data outputs hold their last value when `out_valid`=0.

## Structure
- Shared package `img_pkg`: `DW`, `GRAD_W`, `PIX_MAX`, typedef `pixel_t`, typedef signed `grad_t`.
- Sub-module `pixel_pos_tracker`: `col`/`row` counters, sof resync, wrap, and `interior`/`last_pixel` flags. Gradient arithmetic stays in the top.

## Test plan
- Flat image, all pixels 128, threshold 10 → interior `edge_mag`=0, `edge_bit`=0.
- Vertical step (columns 1–2 = 0, column 3 = 255), threshold 200 → Gx=1020, Gy=0, `edge_mag`=255, `edge_bit`=1.
- Window i13=i23=i33=10, others 0, threshold 40 → magnitude 40, `edge_bit`=1; threshold 41 → `edge_bit`=0.
- Full 100x100 frame with `sof` on first beat → rows 0–1 and columns 0–1 output 0; `eof` exactly once, on the 10000th result; `out_valid` lags `in_valid` by 3 cycles.
- `in_valid` toggling 1,0,1,1,0 → `out_valid` reproduces the pattern 3 cycles later, values unchanged.
- Assert `rst_n`=0 mid-frame with 3 windows in flight → all outputs 0 immediately, no stale `out_valid` after release.
